// File: rtl/ps2_host_tx_if.sv
// Command-byte handshake between a client and the PS/2 host transmitter.
// The client (master) offers bytes; the transmitter (slave) reports status.
interface ps2_host_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;
    logic [1:0] tx_err_code;

    modport master (
        output tx_valid, tx_data,
        input  tx_ready, tx_busy, tx_done, tx_err, tx_err_code
    );

    modport slave (
        input  tx_valid, tx_data,
        output tx_ready, tx_busy, tx_done, tx_err, tx_err_code
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 8 data bits LSB first,
// odd parity, stop, then checks the device ACK. Lines are open-drain (oe=1 pulls low).
module ps2_host_tx #(
    parameter int INHIBIT_CYC  = 12000,
    parameter int START_TO_CYC = 1500000,
    parameter int PKT_TO_CYC   = 200000,
    parameter int FILT_LEN     = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    ps2_host_tx_if.slave  tx,
    input  logic          ps2_clk_in,
    input  logic          ps2_data_in,
    output logic          ps2_clk_oe,
    output logic          ps2_data_oe
);

    localparam int TMAX0 = (INHIBIT_CYC > START_TO_CYC) ? INHIBIT_CYC : START_TO_CYC;
    localparam int TMAX  = (TMAX0 > PKT_TO_CYC) ? TMAX0 : PKT_TO_CYC;
    localparam int TW    = $clog2(TMAX + 2);
    localparam int FW    = $clog2(FILT_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAIT_IDLE, S_DONE, S_ERR
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      code_d, err_code_q;
    logic [9:0]      sreg_q;
    logic [3:0]      bit_cnt_q;
    logic [TW-1:0]   timer_q;

    logic            clk_s1, clk_s2, data_s1, data_s2, clk_f, fe;
    logic [FW-1:0]   filt_cnt;

    logic accept, inh_last, start_to, pkt_to;

    assign accept   = tx.tx_valid && (state_q == S_IDLE);
    assign inh_last = (timer_q == TW'(INHIBIT_CYC - 1));
    assign start_to = (timer_q == TW'(START_TO_CYC));
    assign pkt_to   = (timer_q == TW'(PKT_TO_CYC));

    // Synchronizers; ps2_clk must also hold a new level for FILT_LEN samples
    // before it is accepted, so short glitches never produce an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
            clk_f    <= 1'b1;
            filt_cnt <= '0;
            fe       <= 1'b0;
        end else begin
            clk_s1  <= ps2_clk_in;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data_in;
            data_s2 <= data_s1;
            fe      <= 1'b0;
            if (clk_s2 == clk_f) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
                clk_f    <= clk_s2;
                filt_cnt <= '0;
                fe       <= ~clk_s2;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Timer expiry is checked before the edge so a simultaneous fe loses.
    always_comb begin
        state_d = state_q;
        code_d  = 2'b00;
        case (state_q)
            S_IDLE:    if (accept) state_d = S_INHIBIT;
            S_INHIBIT: if (inh_last) state_d = S_REQ;
            S_REQ: begin
                if (start_to) begin
                    state_d = S_ERR;
                    code_d  = 2'b01;
                end else if (fe) begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (pkt_to) begin
                    state_d = S_ERR;
                    code_d  = 2'b10;
                end else if (fe && bit_cnt_q == 4'd9) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (pkt_to) begin
                    state_d = S_ERR;
                    code_d  = 2'b10;
                end else if (fe) begin
                    if (data_s2) begin
                        state_d = S_ERR;
                        code_d  = 2'b11;
                    end else begin
                        state_d = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (pkt_to) begin
                    state_d = S_ERR;
                    code_d  = 2'b10;
                end else if (clk_s2 && data_s2) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Shift register, edge counter, shared timer and sticky error code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q     <= '0;
            bit_cnt_q  <= '0;
            timer_q    <= '0;
            err_code_q <= 2'b00;
        end else begin
            if (code_d != 2'b00) err_code_q <= code_d;
            case (state_q)
                S_IDLE: begin
                    timer_q <= '0;
                    if (accept) begin
                        sreg_q    <= {1'b1, ~^tx.tx_data, tx.tx_data};
                        bit_cnt_q <= '0;
                    end
                end
                S_INHIBIT: timer_q <= inh_last ? '0 : timer_q + TW'(1);
                S_REQ: begin
                    if (fe) begin
                        timer_q   <= TW'(1);
                        bit_cnt_q <= 4'd1;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                S_SHIFT: begin
                    timer_q <= timer_q + TW'(1);
                    if (fe) begin
                        sreg_q    <= {1'b1, sreg_q[9:1]};
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                    end
                end
                S_ACK, S_WAIT_IDLE: timer_q <= timer_q + TW'(1);
                default: timer_q <= '0;
            endcase
        end
    end

    always_comb begin
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        tx.tx_done  = 1'b0;
        tx.tx_err   = 1'b0;
        case (state_q)
            S_INHIBIT: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = inh_last;
            end
            S_REQ:   ps2_data_oe = 1'b1;
            S_SHIFT: ps2_data_oe = ~sreg_q[0];
            S_DONE:  tx.tx_done  = 1'b1;
            S_ERR:   tx.tx_err   = 1'b1;
            default: ;
        endcase
    end

    assign tx.tx_ready    = (state_q == S_IDLE);
    assign tx.tx_busy     = (state_q != S_IDLE);
    assign tx.tx_err_code = err_code_q;

endmodule
